crc_frame_checker: RTL

Receive-side counterpart of the CRC frame builder: accepts one `{payload, CRC}` frame per handshake and re-divides the whole frame bit-serially by the generator polynomial. It reports the payload together with a pass/fail flag. It sits directly downstream of the transmitter's registered frame output and feeds the payload consumer.

---
 rtl/crc_frame_checker.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/crc_frame_checker.sv
// crc_frame_checker: receive-side CRC checker.
// Accepts one {payload, CRC} frame per handshake, re-divides the whole frame
// bit-serially (MSB first) by POLY, and reports the payload plus a pass flag.
// Optional feature macro: CRC_CHK_ERRCNT_EN adds a saturating 16-bit failed
// frame counter on port err_cnt.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// in_ready is a pure decode of the registered state (no path from in_valid);
// out_valid is a flop (no path from out_ready). Once raised, out_valid and
// the result hold until accepted.
module crc_frame_checker #(
  parameter int                BW     = 40,
  parameter int                CRC_BW = 8,
  parameter logic [CRC_BW-1:0] POLY   = 8'h07
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BW+CRC_BW-1:0] in_frame,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BW-1:0]        out_payload,
  output logic                 crc_ok,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef CRC_CHK_ERRCNT_EN
  ,
  output logic [15:0]          err_cnt
`endif
);

  localparam int FRAME_W = BW + CRC_BW;
  localparam int CNT_W   = $clog2(FRAME_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [CRC_BW-1:0]    rem_q, rem_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]        out_payload_q, out_payload_d;
  logic                 crc_ok_q, crc_ok_d;
  logic                 out_valid_q, out_valid_d;
`ifdef CRC_CHK_ERRCNT_EN
  logic [15:0]          err_cnt_q, err_cnt_d;
`endif

  logic                 bit_in;
  logic                 fb;
  logic [CRC_BW-1:0]    rem_shift;
  logic [CRC_BW-1:0]    rem_next;

  // One division step: the frame is held unshifted and indexed by the
  // counter, so the payload is still intact when the result is registered.
  always_comb begin
    bit_in    = frame_q[cnt_q];
    fb        = rem_q[CRC_BW-1];
    rem_shift = {rem_q[CRC_BW-2:0], bit_in};
    rem_next  = fb ? (rem_shift ^ POLY) : rem_shift;
  end

  // Next-state and next-output logic for the IDLE/SHIFT/DONE controller.
  always_comb begin
    state_d       = state_q;
    frame_d       = frame_q;
    rem_d         = rem_q;
    cnt_d         = cnt_q;
    out_payload_d = out_payload_q;
    crc_ok_d      = crc_ok_q;
    out_valid_d   = out_valid_q;
`ifdef CRC_CHK_ERRCNT_EN
    err_cnt_d     = err_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          frame_d = in_frame;
          rem_d   = '0;
          cnt_d   = CNT_W'(FRAME_W - 1);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        rem_d = rem_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          // Last bit consumed this cycle: publish the result on DONE entry.
          out_payload_d = frame_q[FRAME_W-1:CRC_BW];
          crc_ok_d      = (rem_next == '0);
          out_valid_d   = 1'b1;
          state_d       = ST_DONE;
`ifdef CRC_CHK_ERRCNT_EN
          if ((rem_next != '0) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
          end
`endif
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Single state register for the controller, datapath and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      frame_q       <= '0;
      rem_q         <= '0;
      cnt_q         <= '0;
      out_payload_q <= '0;
      crc_ok_q      <= 1'b0;
      out_valid_q   <= 1'b0;
`ifdef CRC_CHK_ERRCNT_EN
      err_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      frame_q       <= frame_d;
      rem_q         <= rem_d;
      cnt_q         <= cnt_d;
      out_payload_q <= out_payload_d;
      crc_ok_q      <= crc_ok_d;
      out_valid_q   <= out_valid_d;
`ifdef CRC_CHK_ERRCNT_EN
      err_cnt_q     <= err_cnt_d;
`endif
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_payload = out_payload_q;
  assign crc_ok      = crc_ok_q;
  assign out_valid   = out_valid_q;
`ifdef CRC_CHK_ERRCNT_EN
  assign err_cnt     = err_cnt_q;
`endif

endmodule
